// File: rtl/recolector_salida.sv
// Round-robin drain of four output FIFOs onto one valid/ready stream, with
// per-FIFO saturating delivered-word counters readable through req/idx.

module recolector_salida_cnt #(
  parameter int CNT_SIZE = 5
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                inc,
  output logic [CNT_SIZE-1:0] cnt
);
  // Saturates at all-ones; further increments are dropped.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end
endmodule

module recolector_salida #(
  parameter int WORD_SIZE = 10,
  parameter int NUM_OUT   = 4,
  parameter int CNT_SIZE  = 5
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [3:0]           empty_out,
  input  logic [WORD_SIZE-1:0] data_out0,
  input  logic [WORD_SIZE-1:0] data_out1,
  input  logic [WORD_SIZE-1:0] data_out2,
  input  logic [WORD_SIZE-1:0] data_out3,
  output logic                 pop_FIFO_out0,
  output logic                 pop_FIFO_out1,
  output logic                 pop_FIFO_out2,
  output logic                 pop_FIFO_out3,
  output logic [WORD_SIZE-1:0] data_o,
  output logic [1:0]           src_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 req,
  input  logic [1:0]           idx,
  output logic [CNT_SIZE-1:0]  data,
  output logic                 valid
);
  typedef enum logic [1:0] {IDLE, POP, CAPTURE, HOLD} state_t;

  state_t                                state;
  logic [1:0]                            rr_ptr, sel, nxt_sel, cand;
  logic                                  found, start, hs;
  logic [NUM_OUT-1:0]                    pop_vec, inc;
  logic [NUM_OUT-1:0][WORD_SIZE-1:0]     fifo_data;
  logic [NUM_OUT-1:0][CNT_SIZE-1:0]      cnt;

  assign fifo_data = {data_out3, data_out2, data_out1, data_out0};

  // First non-empty FIFO scanning upward from rr_ptr, wrapping mod 4.
  always_comb begin
    nxt_sel = rr_ptr;
    found   = 1'b0;
    cand    = rr_ptr;
    for (int k = 0; k < NUM_OUT; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && !empty_out[cand]) begin
        nxt_sel = cand;
        found   = 1'b1;
      end
    end
  end

  assign start   = (state == IDLE) && enable && found;
  assign pop_vec = start ? (NUM_OUT'(1) << nxt_sel) : '0;
  assign hs      = (state == HOLD) && valid_o && ready_i;

  assign pop_FIFO_out0 = pop_vec[0];
  assign pop_FIFO_out1 = pop_vec[1];
  assign pop_FIFO_out2 = pop_vec[2];
  assign pop_FIFO_out3 = pop_vec[3];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      sel     <= '0;
      data_o  <= '0;
      src_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel   <= nxt_sel;
          state <= POP;
        end
        POP: state <= CAPTURE;   // FIFO read register loads this cycle
        CAPTURE: begin
          data_o  <= fifo_data[sel];
          src_o   <= sel;
          valid_o <= 1'b1;
          state   <= HOLD;
        end
        HOLD: if (hs) begin
          valid_o <= 1'b0;
          rr_ptr  <= sel + 2'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_cnt
    assign inc[n] = hs && (sel == 2'(n));
    recolector_salida_cnt #(.CNT_SIZE(CNT_SIZE)) u_cnt (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (inc[n]),
      .cnt     (cnt[n])
    );
  end

  // Read samples the pre-edge counter, so a same-edge increment is not seen.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= req;
      if (req) data <= cnt[idx];
    end
  end
endmodule

// File: tb/tb_recolector_salida.sv
// Bench for recolector_salida: FIFO model feeding the DUT, stream monitor, and a
// round-robin / saturating-counter reference computed from the FIFO contents.

module tb_recolector_salida;
  localparam int W  = 10;
  localparam int CW = 5;

  logic          clk = 1'b0, reset_L = 1'b0, enable = 1'b0, ready_i = 1'b0, req = 1'b0;
  logic [1:0]    idx = '0;
  logic [3:0]    empty_out;
  logic [W-1:0]  data_out0, data_out1, data_out2, data_out3;
  logic          pop_FIFO_out0, pop_FIFO_out1, pop_FIFO_out2, pop_FIFO_out3;
  logic [W-1:0]  data_o;
  logic [1:0]    src_o;
  logic          valid_o;
  logic [CW-1:0] data;
  logic          valid;

  always #5 clk = ~clk;

  recolector_salida #(.WORD_SIZE(W), .NUM_OUT(4), .CNT_SIZE(CW)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .empty_out(empty_out),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .pop_FIFO_out0(pop_FIFO_out0), .pop_FIFO_out1(pop_FIFO_out1),
    .pop_FIFO_out2(pop_FIFO_out2), .pop_FIFO_out3(pop_FIFO_out3),
    .data_o(data_o), .src_o(src_o), .valid_o(valid_o), .ready_i(ready_i),
    .req(req), .idx(idx), .data(data), .valid(valid)
  );

  // FIFO model: tasks write storage/wr_ptr, the clocked block owns rd_ptr.
  logic [W-1:0] fmem [4][256];
  int           wr_ptr [4] = '{0, 0, 0, 0};
  int           rd_ptr [4] = '{0, 0, 0, 0};
  logic [W-1:0] rd_data [4] = '{default: '0};
  logic [3:0]   pops;

  assign pops = {pop_FIFO_out3, pop_FIFO_out2, pop_FIFO_out1, pop_FIFO_out0};
  assign data_out0 = rd_data[0];
  assign data_out1 = rd_data[1];
  assign data_out2 = rd_data[2];
  assign data_out3 = rd_data[3];

  always_comb for (int n = 0; n < 4; n++) empty_out[n] = (wr_ptr[n] == rd_ptr[n]);

  always @(posedge clk)
    for (int n = 0; n < 4; n++)
      if (pops[n] && wr_ptr[n] != rd_ptr[n]) begin
        rd_data[n] <= fmem[n][rd_ptr[n] % 256];
        rd_ptr[n]  <= rd_ptr[n] + 1;
      end

  // Stream monitor.
  int           cyc = 0, pop_cnt = 0, multi_pop = 0, vo_cycles = 0, hs_n = 0, last_pop_cyc = 0;
  int           hs_cyc  [1024];
  logic [1:0]   hs_src  [1024];
  logic [W-1:0] hs_data [1024];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|pops) begin
      pop_cnt      <= pop_cnt + 1;
      last_pop_cyc <= cyc;
    end
    if ($countones(pops) > 1) multi_pop <= multi_pop + 1;
    if (valid_o) vo_cycles <= vo_cycles + 1;
    if (valid_o && ready_i) begin
      hs_src[hs_n % 1024]  <= src_o;
      hs_data[hs_n % 1024] <= data_o;
      hs_cyc[hs_n % 1024]  <= cyc;
      hs_n                 <= hs_n + 1;
    end
  end

  // Reference model state.
  int           tests = 0, fails = 0;
  int           m_rr = 0;
  int           m_cnt [4] = '{0, 0, 0, 0};
  logic [1:0]   exp_src [$];
  logic [W-1:0] exp_data [$];

  task automatic push(input int n, input logic [W-1:0] w);
    fmem[n][wr_ptr[n] % 256] = w;
    wr_ptr[n] = wr_ptr[n] + 1;
  endtask

  // Expected delivery order of everything currently queued, by the fairness rule.
  task automatic build_expect();
    int rp [4];
    int left;
    left = 0;
    for (int n = 0; n < 4; n++) begin
      rp[n] = rd_ptr[n];
      left += wr_ptr[n] - rd_ptr[n];
    end
    while (left > 0) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_rr + k) % 4;
        if (rp[s] < wr_ptr[s]) begin
          exp_src.push_back(2'(s));
          exp_data.push_back(fmem[s][rp[s] % 256]);
          rp[s]++;
          left--;
          if (m_cnt[s] < 31) m_cnt[s]++;
          m_rr = (s + 1) % 4;
          break;
        end
      end
    end
  endtask

  task automatic drain(input string nm, input int base, input int budget, input bit rnd);
    int n;
    n = exp_src.size();
    for (int c = 0; c < budget; c++) begin
      if (hs_n >= base + n) break;
      @(negedge clk);
      if (rnd) ready_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ready_i = 1'b1;
    tests++;
    if (hs_n != base + n) begin
      fails++;
      $display("FAIL %s_count: got %0d words, expected %0d", nm, hs_n - base, n);
    end
    for (int i = 0; i < n && i < hs_n - base; i++) begin
      tests++;
      if ({hs_src[(base + i) % 1024], hs_data[(base + i) % 1024]} !== {exp_src[i], exp_data[i]}) begin
        fails++;
        $display("FAIL %s_word%0d: got src %0d data %h, expected src %0d data %h", nm, i,
                 hs_src[(base + i) % 1024], hs_data[(base + i) % 1024], exp_src[i], exp_data[i]);
      end
    end
    exp_src.delete();
    exp_data.delete();
  endtask

  task automatic read_cnt(input int i, input int exp, input string nm);
    @(negedge clk);
    req = 1'b1;
    idx = 2'(i);
    @(posedge clk) #1;
    tests++;
    if (valid !== 1'b1 || data !== CW'(exp)) begin
      fails++;
      $display("FAIL %s_read%0d: got valid %b data %0d, expected valid 1 data %0d", nm, i, valid, data, exp);
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk) #1;
    tests++;
    if (valid !== 1'b0 || data !== CW'(exp)) begin
      fails++;
      $display("FAIL %s_hold%0d: got valid %b data %0d, expected valid 0 data %0d", nm, i, valid, data, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    for (int c = 0; c < 40 && valid_o !== 1'b1; c++) @(negedge clk);
    tests++;
    if (valid_o !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: valid_o got %b, expected 1", nm, valid_o);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    enable  = 1'b0;
    ready_i = 1'b0;
    req     = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    m_rr    = 0;
    m_cnt   = '{0, 0, 0, 0};
  endtask

  task automatic test_reset();
    int p0, base;
    #12;
    tests++;
    if ({pops, data_o, src_o, valid_o, data, valid} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h, expected 0", {pops, data_o, src_o, valid_o, data, valid});
    end
    @(negedge clk);
    reset_L = 1'b1;
    push(2, 10'h2A5);
    enable  = 1'b1;
    ready_i = 1'b0;
    wait_valid("reset_hold");
    tests++;
    if (data_o !== 10'h2A5 || src_o !== 2'd2) begin
      fails++;
      $display("FAIL reset_hold_word: got src %0d data %h, expected src 2 data 2a5", src_o, data_o);
    end
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    tests++;
    if ({pops, data_o, src_o, valid_o, data, valid} !== '0) begin
      fails++;
      $display("FAIL reset_async: got %h, expected 0", {pops, data_o, src_o, valid_o, data, valid});
    end
    enable = 1'b0;
    push(1, 10'h0C3);
    @(negedge clk);
    reset_L = 1'b1;
    m_rr    = 0;
    m_cnt   = '{0, 0, 0, 0};
    p0      = pop_cnt;
    repeat (6) @(negedge clk);
    tests++;
    if (pop_cnt != p0) begin
      fails++;
      $display("FAIL reset_nopop: got %0d pops, expected 0", pop_cnt - p0);
    end
    build_expect();
    base    = hs_n;
    ready_i = 1'b1;
    enable  = 1'b1;
    drain("reset_after", base, 40, 1'b0);
    read_cnt(2, 0, "reset_lost");
    enable = 1'b0;
  endtask

  task automatic test_single();
    int p0, v0, base;
    do_reset();
    push(0, 10'h155);
    p0 = pop_cnt;
    v0 = vo_cycles;
    base = hs_n;
    build_expect();
    ready_i = 1'b1;
    enable  = 1'b1;
    drain("single", base, 40, 1'b0);
    tests++;
    if (pop_cnt - p0 != 1 || vo_cycles - v0 != 1) begin
      fails++;
      $display("FAIL single_pulses: got pops %0d valid cycles %0d, expected 1 and 1", pop_cnt - p0, vo_cycles - v0);
    end
    tests++;
    if (hs_cyc[base % 1024] - last_pop_cyc != 3) begin
      fails++;
      $display("FAIL single_latency: got %0d edges pop-to-handshake, expected 3", hs_cyc[base % 1024] - last_pop_cyc);
    end
    read_cnt(0, 1, "single");
    enable = 1'b0;
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    for (int w = 0; w < 2; w++)
      for (int n = 0; n < 4; n++) push(n, W'($urandom));
    base = hs_n;
    build_expect();
    ready_i = 1'b1;
    enable  = 1'b1;
    drain("rr", base, 80, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (hs_src[(base + i) % 1024] !== 2'(i % 4)) begin
        fails++;
        $display("FAIL rr_order%0d: got src %0d, expected %0d", i, hs_src[(base + i) % 1024], i % 4);
      end
    end
    read_cnt(3, 2, "rr");
    for (int n = 0; n < 3; n++) read_cnt(n, m_cnt[n], "rr");
  endtask

  task automatic test_backpressure();
    int p0, base;
    logic [W+2:0] snap;
    ready_i = 1'b0;
    push(1, 10'h3FF);
    base = hs_n;
    build_expect();
    enable = 1'b1;
    wait_valid("bp");
    snap = {data_o, src_o, valid_o};
    p0   = pop_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({data_o, src_o, valid_o} !== snap || snap !== {10'h3FF, 2'd1, 1'b1}) begin
        fails++;
        $display("FAIL bp_stable%0d: got %h, expected %h", c, {data_o, src_o, valid_o}, {10'h3FF, 2'd1, 1'b1});
      end
    end
    tests++;
    if (pop_cnt != p0) begin
      fails++;
      $display("FAIL bp_nopop: got %0d pops during stall, expected 0", pop_cnt - p0);
    end
    ready_i = 1'b1;
    drain("bp", base, 20, 1'b0);
    repeat (5) @(negedge clk);
    tests++;
    if (hs_n - base != 1) begin
      fails++;
      $display("FAIL bp_once: got %0d handshakes, expected 1", hs_n - base);
    end
    enable = 1'b0;
  endtask

  task automatic test_saturation();
    int base;
    do_reset();
    for (int i = 0; i < 35; i++) push(3, W'($urandom));
    base = hs_n;
    build_expect();
    ready_i = 1'b1;
    enable  = 1'b1;
    drain("sat", base, 35 * 4 + 50, 1'b0);
    read_cnt(3, 31, "sat");
    for (int n = 0; n < 3; n++) read_cnt(n, 0, "sat");
    enable = 1'b0;
  endtask

  task automatic test_enable();
    int p0, base;
    do_reset();
    for (int n = 0; n < 4; n++) push(n, W'($urandom));
    p0 = pop_cnt;
    repeat (8) @(negedge clk);
    tests++;
    if (pop_cnt != p0) begin
      fails++;
      $display("FAIL en_gate: got %0d pops with enable low, expected 0", pop_cnt - p0);
    end
    base = hs_n;
    build_expect();
    ready_i = 1'b1;
    enable  = 1'b1;
    drain("en", base, 60, 1'b0);
    tests++;
    if (hs_src[base % 1024] !== 2'd0) begin
      fails++;
      $display("FAIL en_first: got src %0d, expected 0", hs_src[base % 1024]);
    end
  endtask

  task automatic test_collision();
    int old, base;
    ready_i = 1'b0;
    push(2, W'($urandom));
    old  = m_cnt[2];
    base = hs_n;
    build_expect();
    enable = 1'b1;
    wait_valid("coll");
    req     = 1'b1;
    idx     = 2'd2;
    ready_i = 1'b1;
    @(posedge clk) #1;
    tests++;
    if (valid !== 1'b1 || data !== CW'(old)) begin
      fails++;
      $display("FAIL coll_read: got valid %b data %0d, expected valid 1 data %0d", valid, data, old);
    end
    req = 1'b0;
    drain("coll", base, 20, 1'b0);
    read_cnt(2, m_cnt[2], "coll_after");
  endtask

  task automatic test_random();
    int base;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) begin
        int k;
        k = $urandom_range(0, 5);
        for (int j = 0; j < k; j++) push(n, W'($urandom));
      end
      base = hs_n;
      build_expect();
      enable = 1'b1;
      drain("rand", base, 600, 1'b1);
    end
    for (int n = 0; n < 4; n++) read_cnt(n, m_cnt[n], "rand");
    tests++;
    if (multi_pop != 0) begin
      fails++;
      $display("FAIL onehot_pop: got %0d cycles with multiple pops, expected 0", multi_pop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_enable();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/recolector_salida.md
Name: recolector_salida

Overview:
- Downstream drain stage for the transaction layer's four output FIFOs.
- Watches the FIFO empty flags and pops one word at a time, visiting non-empty FIFOs in round-robin order.
- Presents each word on a single valid/ready stream tagged with its source FIFO index.
- Keeps a per-FIFO delivered-word counter, read through a req/idx port (registered read, 5-bit result).

Parameters:
- WORD_SIZE, 10, width of one FIFO word and of the data_o stream.
- NUM_OUT, 4, number of output FIFOs drained. Fixed at 4: port list and idx width depend on it.
- CNT_SIZE, 5, width of each per-FIFO delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- enable  input  1  1 = block may start new pops; 0 = finishes the current word, then idles.
- empty_out  input  4  empty flags of output FIFOs 0..3; bit n high = FIFO n empty.
- data_out0..data_out3  input  WORD_SIZE each  FIFO read data. Registered in the FIFO: valid the cycle after pop.
- pop_FIFO_out0..pop_FIFO_out3  output  1 each  one-cycle pop strobes; at most one high per cycle.
- data_o  output  WORD_SIZE  collected word.
- src_o  output  2  index of the FIFO that data_o came from.
- valid_o  output  1  data_o/src_o valid.
- ready_i  input  1  consumer accepts when valid_o & ready_i at a rising edge.
- req  input  1  counter read request.
- idx  input  2  counter select for a read.
- data  output  CNT_SIZE  counter read value.
- valid  output  1  data valid, one cycle.

Behaviour:
- Reset (reset_L low, async):
  - state=IDLE, rr_ptr=0, all counters=0.
  - All pops=0, data_o=0, src_o=0, valid_o=0, data=0, valid=0.
  - A word already popped but not yet delivered is lost; this is intended.
- FSM states: IDLE, POP, CAPTURE, HOLD.
- IDLE:
  - If enable=1 and empty_out != 4'b1111: sel = first n with empty_out[n]=0, scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Assert pop_FIFO_out[sel] combinationally this cycle; next state POP.
  - Otherwise stay in IDLE with no pop.
- POP: one cycle; the FIFO updates its read data. No pop asserted. Next state CAPTURE.
- CAPTURE:
  - data_o <= data_out[sel], src_o <= sel, valid_o <= 1.
  - Next state HOLD.
- HOLD:
  - valid_o stays 1; data_o and src_o are stable until the handshake.
  - On valid_o & ready_i: valid_o <= 0, counter[sel] increments, rr_ptr <= sel+1 (mod 4), next state IDLE.
  - ready_i=0 stalls indefinitely; no pops occur while stalled.
- Throughput: at most one word every 4 cycles (IDLE, POP, CAPTURE, HOLD) with ready_i tied high.
  - The 2+ cycle gap between pops guarantees the empty flags have updated before the next IDLE sample.
- enable is sampled only in IDLE; deasserting it mid-word does not abort the word.
- Counters:
  - Saturate at 2^CNT_SIZE-1 (31); increments beyond that are dropped.
  - Modulo wrap is not allowed.
- Counter read:
  - req=1 at an edge: next cycle data = counter[idx] value before any same-edge increment, and valid=1 for exactly one cycle.
  - req=0: valid=0 and data holds its last value.
  - Back-to-back req gives consecutive reads, one per cycle.
  - A read and an increment of the same counter in the same edge: the read returns the old value and the counter still increments.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: pop FIFO 2 (word 10'h2A5), hold ready_i=0, pulse reset_L low asynchronously.
  - Response: valid_o drops immediately without waiting for clk; all outputs 0; no pop until enable and a non-empty flag are seen.
- Single word, ready_i=1:
  - Stimulus: empty_out=4'b1110, data_out0=10'h155 the cycle after pop.
  - Response: pop_FIFO_out0 high exactly 1 cycle; data_o=10'h155, src_o=0, valid_o high 1 cycle, 2 cycles after the pop; counter0=1.
- Round-robin fairness:
  - Stimulus: all four FIFOs non-empty with 2 words each, ready_i=1.
  - Response: src_o sequence 0,1,2,3,0,1,2,3; counters all 2; read req idx=3 gives data=2, valid 1 cycle.
- Backpressure:
  - Stimulus: word 10'h3FF from FIFO 1, ready_i=0 for 10 cycles, then 1.
  - Response: data_o, src_o and valid_o stable for 10 cycles; no pop_FIFO_out strobes during the stall; exactly one handshake afterwards.
- Saturation:
  - Stimulus: 35 words delivered from FIFO 3.
  - Response: counter3 reads 31; other counters 0.
- enable gating:
  - Stimulus: enable=0 with empty_out=4'b0000.
  - Response: no pop strobes; raising enable gives the first pop on FIFO rr_ptr (0 after reset).
